// File: rtl/saturn_ascent_pkg.sv
// Shared constants and arithmetic helpers for the Saturn ascent model.
// Exposes data width, physical constants, trig-table geometry and two
// helpers: a saturating subtract and a Q1.16 multiply that keeps only
// the integer part.
package saturn_ascent_pkg;

    localparam int N        = 64;
    localparam int W2       = 2 * N;
    localparam int LUT_BITS = 6;
    localparam int TRIG_W   = 17;   // Q1.16 needs 17 bits to hold 1.0
    localparam int Q_FRAC   = 16;

    localparam logic [N-1:0] GRAVITY       = 64'd9799;
    localparam logic [N-1:0] STEPS_PER_SEC = 64'd1000;
    localparam logic [N-1:0] ALT_GIMBAL    = 64'd30_000_000_000_000;
    localparam logic [N-1:0] G_PER_KG      = 64'd1000;
    localparam logic [31:0]  PITCH_RATE    = 32'd42950;
    localparam logic [31:0]  THETA_MAX     = 32'hFFFF_FFFF;

    // a - b, clamped at zero instead of wrapping
    function automatic logic [N-1:0] sat_sub(input logic [N-1:0] a, input logic [N-1:0] b);
        if (a >= b) begin
            sat_sub = a - b;
        end else begin
            sat_sub = '0;
        end
    endfunction

    // (a * b) >> 16 computed in double width, truncated back to N bits
    function automatic logic [N-1:0] mul_q16(input logic [N-1:0] a, input logic [N-1:0] b);
        mul_q16 = N'((W2'(a) * W2'(b)) >> Q_FRAC);
    endfunction

endpackage

// File: rtl/saturn_ascent_dynamics_if.sv
// Stage-parameter / telemetry bundle between the launch sequencer
// (master) and the ascent dynamics block (slave).
//   stage controls : stage_rst_n, backward
//   stage params   : specific_impulse, initial_weight, propellant_weight, burntime
//   feedback       : height (external path-length integrator, nm)
//   telemetry      : velocity, after_weight, ignition_end, gimbal_enable,
//                    angular_velocity, noair_altitude, noair_distance,
//                    additional_altitude, distance
interface saturn_ascent_dynamics_if;
    import saturn_ascent_pkg::*;

    logic         stage_rst_n;
    logic         backward;
    logic [N-1:0] specific_impulse;
    logic [N-1:0] initial_weight;
    logic [N-1:0] propellant_weight;
    logic [N-1:0] burntime;
    logic [N-1:0] height;

    logic [N-1:0] velocity;
    logic [N-1:0] after_weight;
    logic         ignition_end;
    logic         gimbal_enable;
    logic [N-1:0] angular_velocity;
    logic [N-1:0] noair_altitude;
    logic [N-1:0] noair_distance;
    logic [N-1:0] additional_altitude;
    logic [N-1:0] distance;

    modport slave (
        input  stage_rst_n, backward, specific_impulse, initial_weight,
               propellant_weight, burntime, height,
        output velocity, after_weight, ignition_end, gimbal_enable, angular_velocity,
               noair_altitude, noair_distance, additional_altitude, distance
    );

    modport master (
        output stage_rst_n, backward, specific_impulse, initial_weight,
               propellant_weight, burntime, height,
        input  velocity, after_weight, ignition_end, gimbal_enable, angular_velocity,
               noair_altitude, noair_distance, additional_altitude, distance
    );

endinterface

// File: rtl/quarter_sine_lut.sv
// Quarter-wave trig table, unsigned Q1.16. Entry k is the angle
// k * 90deg / 63, so index 0 is 0deg and index 63 is 90deg.
//   idx_i : table index
//   sin_o : sin(angle) * 65536
//   cos_o : cos(angle) * 65536 (read from the mirrored sine entry)
module quarter_sine_lut
    import saturn_ascent_pkg::*;
(
    input  logic [LUT_BITS-1:0] idx_i,
    output logic [TRIG_W-1:0]   sin_o,
    output logic [TRIG_W-1:0]   cos_o
);

    function automatic logic [TRIG_W-1:0] qsin(input logic [LUT_BITS-1:0] k);
        case (k)
            6'd0:  qsin = 17'd0;     6'd1:  qsin = 17'd1634;  6'd2:  qsin = 17'd3267;  6'd3:  qsin = 17'd4898;
            6'd4:  qsin = 17'd6525;  6'd5:  qsin = 17'd8149;  6'd6:  qsin = 17'd9768;  6'd7:  qsin = 17'd11380;
            6'd8:  qsin = 17'd12986; 6'd9:  qsin = 17'd14583; 6'd10: qsin = 17'd16172; 6'd11: qsin = 17'd17750;
            6'd12: qsin = 17'd19317; 6'd13: qsin = 17'd20872; 6'd14: qsin = 17'd22415; 6'd15: qsin = 17'd23943;
            6'd16: qsin = 17'd25457; 6'd17: qsin = 17'd26954; 6'd18: qsin = 17'd28435; 6'd19: qsin = 17'd29898;
            6'd20: qsin = 17'd31343; 6'd21: qsin = 17'd32768; 6'd22: qsin = 17'd34173; 6'd23: qsin = 17'd35556;
            6'd24: qsin = 17'd36918; 6'd25: qsin = 17'd38256; 6'd26: qsin = 17'd39571; 6'd27: qsin = 17'd40861;
            6'd28: qsin = 17'd42126; 6'd29: qsin = 17'd43364; 6'd30: qsin = 17'd44576; 6'd31: qsin = 17'd45760;
            6'd32: qsin = 17'd46915; 6'd33: qsin = 17'd48041; 6'd34: qsin = 17'd49138; 6'd35: qsin = 17'd50203;
            6'd36: qsin = 17'd51238; 6'd37: qsin = 17'd52241; 6'd38: qsin = 17'd53211; 6'd39: qsin = 17'd54148;
            6'd40: qsin = 17'd55052; 6'd41: qsin = 17'd55921; 6'd42: qsin = 17'd56756; 6'd43: qsin = 17'd57555;
            6'd44: qsin = 17'd58319; 6'd45: qsin = 17'd59046; 6'd46: qsin = 17'd59737; 6'd47: qsin = 17'd60390;
            6'd48: qsin = 17'd61006; 6'd49: qsin = 17'd61583; 6'd50: qsin = 17'd62123; 6'd51: qsin = 17'd62625;
            6'd52: qsin = 17'd63087; 6'd53: qsin = 17'd63510; 6'd54: qsin = 17'd63893; 6'd55: qsin = 17'd64237;
            6'd56: qsin = 17'd64540; 6'd57: qsin = 17'd64804; 6'd58: qsin = 17'd65027; 6'd59: qsin = 17'd65210;
            6'd60: qsin = 17'd65353; 6'd61: qsin = 17'd65455; 6'd62: qsin = 17'd65516; 6'd63: qsin = 17'd65536;
            default: qsin = 17'd0;
        endcase
    endfunction

    // cos(k) equals sin of the complementary index
    always_comb begin
        sin_o = qsin(idx_i);
        cos_o = qsin(6'd63 - idx_i);
    end

endmodule

// File: rtl/saturn_ascent_dynamics.sv
// Ascent dynamics for one stage at a time: integrates speed from engine
// thrust and gravity, burns down stage mass, detects the 30 km pitch-over
// and then splits fed-back path length into altitude and downrange.
//   CLK, RESETB : one integration step per clock, async active-low reset
//   sa_if       : stage controls/parameters in, height feedback in,
//                 velocity / mass / gimbal telemetry out (all registered)
module saturn_ascent_dynamics
    import saturn_ascent_pkg::*;
(
    input  logic                     CLK,
    input  logic                     RESETB,
    saturn_ascent_dynamics_if.slave  sa_if
);

    logic [N-1:0] mdot_q, mdot_d, force_q, force_d, mass_q, mass_d;
    logic [N-1:0] after_weight_q, after_weight_d, step_q, step_d, target_q, target_d;
    logic [N-1:0] vel_q, vel_d, noair_alt_q, noair_alt_d, ang_vel_q, ang_vel_d;
    logic [N-1:0] prev_h_q, prev_h_d, add_alt_q, add_alt_d, dist_q, dist_d;
    logic         ign_end_q, ign_end_d, gimbal_q, gimbal_d;
    logic [31:0]  theta_q, theta_d;

    logic [N-1:0]          burntime_eff_s, thrust_s, dh_s;
    logic [N:0]            vel_sum_s;
    logic [32:0]           theta_sum_s;
    logic [LUT_BITS-1:0]   lut_idx_s;
    logic [TRIG_W-1:0]     sin_s, cos_s;

    quarter_sine_lut u_lut (
        .idx_i (lut_idx_s),
        .sin_o (sin_s),
        .cos_o (cos_s)
    );

    // Stage load and per-step velocity / mass integration
    always_comb begin
        burntime_eff_s = (sa_if.burntime == 64'd0) ? 64'd1 : sa_if.burntime;
        mdot_d         = mdot_q;
        force_d        = force_q;
        mass_d         = mass_q;
        step_d         = step_q;
        target_d       = target_q;
        ign_end_d      = ign_end_q;
        vel_d          = vel_q;
        thrust_s       = '0;
        vel_sum_s      = '0;
        if (!sa_if.stage_rst_n) begin
            mdot_d    = sa_if.propellant_weight / burntime_eff_s;
            force_d   = N'(W2'(sa_if.specific_impulse) * W2'(GRAVITY) * W2'(mdot_d));
            mass_d    = N'(W2'(sa_if.initial_weight) * W2'(G_PER_KG));
            target_d  = N'(W2'(burntime_eff_s) * W2'(STEPS_PER_SEC));
            step_d    = '0;
            ign_end_d = 1'b0;
        end else if (!ign_end_q) begin
            // thrust acceleration uses the mass before this step's burn
            if (sa_if.backward || (mass_q == 64'd0)) begin
                thrust_s = '0;
            end else begin
                thrust_s = N'((W2'(force_q) * W2'(G_PER_KG)) / W2'(mass_q));
            end
            vel_sum_s = {1'b0, vel_q} + {1'b0, thrust_s};
            if (vel_sum_s >= {1'b0, GRAVITY}) begin
                vel_d = N'(vel_sum_s - {1'b0, GRAVITY});
            end else begin
                vel_d = '0;
            end
            if (sa_if.backward) begin
                mass_d = mass_q;
            end else begin
                mass_d = sat_sub(mass_q, mdot_q);
            end
            step_d    = step_q + 64'd1;
            ign_end_d = (step_d == target_q);
        end else begin
            vel_d  = vel_q;
            mass_d = mass_q;
        end
        after_weight_d = mass_d / G_PER_KG;
    end

    // Pitch-over detection, pitch angle and altitude / downrange split
    always_comb begin
        dh_s        = sat_sub(sa_if.height, prev_h_q);
        theta_sum_s = {1'b0, theta_q} + {1'b0, PITCH_RATE};
        lut_idx_s   = theta_q[31:32-LUT_BITS];
        prev_h_d    = sa_if.height;
        if (gimbal_q) begin
            theta_d   = theta_sum_s[32] ? THETA_MAX : theta_sum_s[31:0];
            add_alt_d = add_alt_q + mul_q16(dh_s, N'(cos_s));
            dist_d    = dist_q + mul_q16(dh_s, N'(sin_s));
        end else begin
            theta_d   = theta_q;
            add_alt_d = add_alt_q;
            dist_d    = dist_q;
        end
        // pitch-over is sticky; only RESETB re-arms it
        if (!gimbal_q && (sa_if.height >= ALT_GIMBAL)) begin
            gimbal_d    = 1'b1;
            noair_alt_d = sa_if.height;
        end else begin
            gimbal_d    = gimbal_q;
            noair_alt_d = noair_alt_q;
        end
        ang_vel_d = gimbal_d ? {32'd0, PITCH_RATE} : 64'd0;
    end

    // State registers
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            mdot_q <= '0; force_q <= '0; mass_q <= '0; after_weight_q <= '0;
            step_q <= '0; target_q <= '0; ign_end_q <= 1'b0; vel_q <= '0;
            gimbal_q <= 1'b0; noair_alt_q <= '0; ang_vel_q <= '0; theta_q <= '0;
            prev_h_q <= '0; add_alt_q <= '0; dist_q <= '0;
        end else begin
            mdot_q <= mdot_d; force_q <= force_d; mass_q <= mass_d; after_weight_q <= after_weight_d;
            step_q <= step_d; target_q <= target_d; ign_end_q <= ign_end_d; vel_q <= vel_d;
            gimbal_q <= gimbal_d; noair_alt_q <= noair_alt_d; ang_vel_q <= ang_vel_d; theta_q <= theta_d;
            prev_h_q <= prev_h_d; add_alt_q <= add_alt_d; dist_q <= dist_d;
        end
    end

    assign sa_if.velocity            = vel_q;
    assign sa_if.after_weight        = after_weight_q;
    assign sa_if.ignition_end        = ign_end_q;
    assign sa_if.gimbal_enable       = gimbal_q;
    assign sa_if.angular_velocity    = ang_vel_q;
    assign sa_if.noair_altitude      = noair_alt_q;
    assign sa_if.noair_distance      = '0;    // launch is straight up until pitch-over
    assign sa_if.additional_altitude = add_alt_q;
    assign sa_if.distance            = dist_q;

endmodule

// File: tb/tb_saturn_ascent_dynamics.sv
// Self-checking bench for saturn_ascent_dynamics: directed scenarios plus a
// randomized phase, all outputs compared every cycle against a behavioural
// model of the ascent rules.
module tb_saturn_ascent_dynamics;
    import saturn_ascent_pkg::*;

    localparam logic [63:0] T_G    = 64'd9799;
    localparam logic [63:0] T_ALT  = 64'd30_000_000_000_000;
    localparam logic [63:0] T_RATE = 64'd42950;

    logic clk = 1'b0;
    logic resetb;
    saturn_ascent_dynamics_if bus();

    saturn_ascent_dynamics dut (
        .CLK    (clk),
        .RESETB (resetb),
        .sa_if  (bus)
    );

    logic [5:0]  lut_idx;
    logic [16:0] lut_sin, lut_cos;
    quarter_sine_lut u_lut_chk (.idx_i(lut_idx), .sin_o(lut_sin), .cos_o(lut_cos));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] m_vel, m_mass, m_mdot, m_force, m_steps, m_target;
    logic [63:0] m_noair, m_prev, m_alt, m_dist;
    logic [31:0] m_theta;
    bit          m_end, m_gim;

    function automatic logic [16:0] ref_trig(input int idx, input bit want_cos);
        real a, r;
        a = real'(idx) * 1.5707963267948966 / 63.0;
        r = want_cos ? $cos(a) : $sin(a);
        return 17'($rtoi(r * 65536.0 + 0.5));
    endfunction

    task automatic model_reset();
        m_vel = 0; m_mass = 0; m_mdot = 0; m_force = 0; m_steps = 0; m_target = 0;
        m_noair = 0; m_prev = 0; m_alt = 0; m_dist = 0; m_theta = 0; m_end = 0; m_gim = 0;
    endtask

    // Apply one clock edge of the ascent rules to the model state
    task automatic model_edge();
        logic [127:0] p, vs;
        logic [63:0]  bt, thr, dh;
        logic [32:0]  th;
        int           idx;
        if (!resetb) begin
            model_reset();
            return;
        end
        if (!bus.stage_rst_n) begin
            bt       = (bus.burntime == 64'd0) ? 64'd1 : bus.burntime;
            m_mdot   = bus.propellant_weight / bt;
            p        = 128'(bus.specific_impulse) * 128'd9799 * 128'(m_mdot);
            m_force  = p[63:0];
            p        = 128'(bus.initial_weight) * 128'd1000;
            m_mass   = p[63:0];
            m_target = bt * 64'd1000;
            m_steps  = 0;
            m_end    = 0;
        end else if (!m_end) begin
            thr = 0;
            if (!bus.backward && m_mass != 0) begin
                p   = (128'(m_force) * 128'd1000) / 128'(m_mass);
                thr = p[63:0];
            end
            vs    = 128'(m_vel) + 128'(thr);
            m_vel = (vs >= 128'(T_G)) ? 64'(vs - 128'(T_G)) : 64'd0;
            if (!bus.backward) m_mass = (m_mass > m_mdot) ? m_mass - m_mdot : 64'd0;
            m_steps++;
            if (m_steps == m_target) m_end = 1;
        end
        if (m_gim) begin
            dh     = (bus.height > m_prev) ? bus.height - m_prev : 64'd0;
            idx    = int'(m_theta >> 26);
            p      = (128'(dh) * 128'(ref_trig(idx, 1'b1))) >> 16;
            m_alt  = m_alt + p[63:0];
            p      = (128'(dh) * 128'(ref_trig(idx, 1'b0))) >> 16;
            m_dist = m_dist + p[63:0];
            th     = 33'(m_theta) + 33'(T_RATE);
            m_theta = (th > 33'h0_FFFF_FFFF) ? 32'hFFFF_FFFF : th[31:0];
        end else if (bus.height >= T_ALT) begin
            m_gim   = 1;
            m_noair = bus.height;
        end
        m_prev = bus.height;
    endtask

    task automatic compare_all(input string ph);
        check_eq({ph, ".velocity"},      bus.velocity,            m_vel);
        check_eq({ph, ".after_weight"},  bus.after_weight,        m_mass / 64'd1000);
        check_eq({ph, ".ignition_end"},  64'(bus.ignition_end),   64'(m_end));
        check_eq({ph, ".gimbal_enable"}, 64'(bus.gimbal_enable),  64'(m_gim));
        check_eq({ph, ".angular_vel"},   bus.angular_velocity,    m_gim ? T_RATE : 64'd0);
        check_eq({ph, ".noair_alt"},     bus.noair_altitude,      m_noair);
        check_eq({ph, ".noair_dist"},    bus.noair_distance,      64'd0);
        check_eq({ph, ".add_alt"},       bus.additional_altitude, m_alt);
        check_eq({ph, ".distance"},      bus.distance,            m_dist);
    endtask

    task automatic tick(input string ph);
        model_edge();
        @(posedge clk);
        #1;
        compare_all(ph);
    endtask

    task automatic load_stage(input logic [63:0] isp, input logic [63:0] iw,
                              input logic [63:0] pw, input logic [63:0] bt, input string ph);
        bus.specific_impulse  = isp;
        bus.initial_weight    = iw;
        bus.propellant_weight = pw;
        bus.burntime          = bt;
        bus.stage_rst_n       = 1'b0;
        tick(ph);
        bus.stage_rst_n       = 1'b1;
    endtask

    logic [63:0] saved_v, h_cur;
    int          d;

    initial begin
        resetb = 1'b0;
        bus.stage_rst_n = 1'b1; bus.backward = 1'b0; bus.height = 64'd0;
        bus.specific_impulse = 64'd0; bus.initial_weight = 64'd0;
        bus.propellant_weight = 64'd0; bus.burntime = 64'd1;
        lut_idx = 6'd0;
        model_reset();

        // reset state
        tick("reset");
        check_eq("reset_velocity", bus.velocity, 64'd0);
        check_eq("reset_gimbal", 64'(bus.gimbal_enable), 64'd0);
        resetb = 1'b1;

        // stage 1 first-step velocity
        load_stage(64'd363, 64'd2_877_403, 64'd2_077_000, 64'd48, "s1_load");
        check_eq("s1_load_weight", bus.after_weight, 64'd2_877_403);
        tick("s1_step");
        check_eq("s1_first_vel", bus.velocity, 64'd43_691);
        check_eq("s1_first_weight", bus.after_weight, 64'd2_877_359);

        // one-second burn: ignition_end timing, final mass, frozen velocity
        load_stage(64'd300, 64'd1000, 64'd100, 64'd1, "burn_load");
        for (int i = 1; i <= 1000; i++) begin
            tick("burn");
            if (i == 999)  check_eq("burn_end_early", 64'(bus.ignition_end), 64'd0);
            if (i == 1000) check_eq("burn_end_at_1000", 64'(bus.ignition_end), 64'd1);
        end
        check_eq("burn_after_weight", bus.after_weight, 64'd900);
        saved_v = m_vel;
        for (int i = 0; i < 20; i++) tick("frozen");
        check_eq("burn_vel_frozen", bus.velocity, saved_v);

        // coast from rest: gravity saturates at zero, mass frozen
        resetb = 1'b0; tick("coast_rst"); resetb = 1'b1;
        bus.backward = 1'b1;
        load_stage(64'd250, 64'd5000, 64'd1000, 64'd2, "coast_load");
        for (int i = 0; i < 50; i++) tick("coast");
        check_eq("coast_vel_zero", bus.velocity, 64'd0);
        check_eq("coast_weight_kept", bus.after_weight, 64'd5000);
        bus.backward = 1'b0;

        // pitch-over at exactly 30 km, then index-0 resolution
        bus.height = 64'd29_999_999_999_000;
        tick("pre_gimbal");
        check_eq("gimbal_below_thr", 64'(bus.gimbal_enable), 64'd0);
        bus.height = 64'd30_000_000_000_000;
        tick("gimbal_edge");
        check_eq("gimbal_rise", 64'(bus.gimbal_enable), 64'd1);
        check_eq("gimbal_noair", bus.noair_altitude, 64'd30_000_000_000_000);
        check_eq("gimbal_angvel", bus.angular_velocity, 64'd42_950);
        for (int k = 1; k <= 10; k++) begin
            bus.height = bus.height + 64'd1_000_000;
            tick("pitch");
            check_eq("pitch_add_alt", bus.additional_altitude, 64'(k) * 64'd1_000_000);
            check_eq("pitch_distance", bus.distance, 64'd0);
        end

        // trig table against the reference trig functions
        for (int k = 0; k < 64; k++) begin
            lut_idx = 6'(k);
            #1;
            d = int'(lut_sin) - int'(ref_trig(k, 1'b0));
            check_eq("lut_sin_close", 64'(d >= -2 && d <= 2), 64'd1);
            d = int'(lut_cos) - int'(ref_trig(k, 1'b1));
            check_eq("lut_cos_close", 64'(d >= -2 && d <= 2), 64'd1);
        end
        lut_idx = 6'd0;  #1;
        check_eq("lut_cos0", 64'(lut_cos), 64'd65536);
        check_eq("lut_sin0", 64'(lut_sin), 64'd0);
        lut_idx = 6'd63; #1;
        check_eq("lut_sin63", 64'(lut_sin), 64'd65536);
        check_eq("lut_cos63", 64'(lut_cos), 64'd0);

        // randomized flight: restarts, coast toggles, noisy height crossing 30 km
        resetb = 1'b0; tick("rand_rst"); resetb = 1'b1;
        h_cur = T_ALT - 64'd300_000_000;
        bus.height = h_cur;
        load_stage(64'($urandom_range(200, 450)), 64'($urandom_range(1000, 3_000_000)),
                   64'($urandom_range(0, 900)), 64'($urandom_range(1, 2)), "rand_load");
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                bus.initial_weight    = 64'($urandom_range(1000, 3_000_000));
                bus.propellant_weight = 64'($urandom_range(0, 900_000));
                bus.specific_impulse  = 64'($urandom_range(200, 450));
                bus.burntime          = 64'($urandom_range(1, 2));
                bus.stage_rst_n       = 1'b0;
            end else begin
                bus.stage_rst_n = 1'b1;
            end
            if ($urandom_range(0, 49) == 0) bus.backward = ~bus.backward;
            if ($urandom_range(0, 7) == 0) h_cur = h_cur - 64'($urandom_range(0, 500_000));
            else                           h_cur = h_cur + 64'($urandom_range(0, 2_000_000));
            bus.height = h_cur;
            tick("rand");
        end
        bus.backward = 1'b0;
        bus.stage_rst_n = 1'b1;

        // asynchronous reset mid-burn, then gimbal re-arms
        load_stage(64'd300, 64'd2000, 64'd500, 64'd3, "mid_load");
        for (int i = 0; i < 20; i++) tick("mid_burn");
        #2;
        resetb = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        check_eq("async_rst_vel", bus.velocity, 64'd0);
        check_eq("async_rst_gimbal", 64'(bus.gimbal_enable), 64'd0);
        tick("held_rst");
        resetb = 1'b1;
        tick("rearm");
        check_eq("rearm_gimbal", 64'(bus.gimbal_enable), 64'd1);
        check_eq("rearm_noair", bus.noair_altitude, h_cur);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/saturn_ascent_dynamics.md
Name: saturn_ascent_dynamics

Overview:
- Single-stage-at-a-time ascent model for the launch simulator.
- Integrates rocket velocity from the stage engine parameters.
- Detects the 30 km pitch-over point and then resolves path length into altitude and downrange distance using the pitch angle.
- The height (path-length) integrator is external and feeds `height` back into this block.

Parameters:
- N, 64: width of all data ports.
- GRAVITY, 9799: velocity loss per step from gravity, in µm/s (9.799 m/s² × 1 ms).
- STEPS_PER_SEC, 1000: integration steps per simulated second; one step per CLK cycle.
- ALT_GIMBAL, 30_000_000_000_000: pitch-over threshold in nm (30 km).
- PITCH_RATE, 42950: angle increment per step, in units of 2^-32 quarter-turn (≈100 s to 90°).
- LUT_BITS, 6: trig table index width.

Ports:
- CLK, in, 1: clock.
- RESETB, in, 1: asynchronous, active-low reset.
- stage_rst_n, in, 1: synchronous active-low stage restart (loads stage inputs).
- backward, in, 1: coast mode. Thrust term is 0, mass is frozen, gravity still applies.
- specific_impulse, in, N: Isp in s.
- initial_weight, in, N: stage-start mass in kg.
- propellant_weight, in, N: stage propellant in kg.
- burntime, in, N: burn duration in s.
- height, in, N: integrated path length in nm.
- velocity, out, N: speed in µm/s, unsigned.
- after_weight, out, N: current mass in kg.
- ignition_end, out, 1: burn complete.
- gimbal_enable, out, 1: pitch-over active (sticky).
- angular_velocity, out, N: PITCH_RATE when gimbal_enable is high, else 0.
- noair_altitude, out, N: height latched at pitch-over, in nm.
- noair_distance, out, N: downrange latched at pitch-over; always 0.
- additional_altitude, out, N: altitude gained since pitch-over, in nm.
- distance, out, N: downrange since pitch-over, in nm.

Behaviour:
- RESETB low clears all registers and outputs to 0, including the angle accumulator and the previous-height register.
- Stage restart (stage_rst_n low on a CLK edge) does the following:
  - mdot = propellant_weight / burntime, integer division; a burntime of 0 is treated as 1.
  - F = specific_impulse × GRAVITY × mdot, in mN.
  - mass_g = initial_weight × 1000.
  - step counter cleared; ignition_end cleared.
  - velocity and all gimbal state are retained.
- Each cycle with stage_rst_n high and ignition_end low:
  - dv = (backward ? 0 : F × 1000 / mass_g) − GRAVITY, using mass_g before decrement; a mass_g of 0 makes the thrust term 0.
  - velocity = max(0, velocity + dv), with saturation at 0.
  - If backward is low: mass_g −= mdot, saturating at 0.
  - step counter += 1.
- after_weight = mass_g / 1000.
- ignition_end goes high on the edge where the step count reaches burntime × STEPS_PER_SEC. It holds until stage restart or RESETB. While it is high, velocity and mass are frozen.
- Gimbal: on the first edge where height ≥ ALT_GIMBAL, set gimbal_enable and latch noair_altitude = height. Never clears except on RESETB.
- While gimbal_enable is high, each cycle:
  - theta += PITCH_RATE, as a 32-bit accumulator saturating at 2^32−1 (90°).
  - dh = height − prev_height, clamped to ≥0.
  - additional_altitude += (dh × cosLUT[idx]) >> 16.
  - distance += (dh × sinLUT[idx]) >> 16.
  - idx = theta[31:32−LUT_BITS].
  - prev_height is updated every cycle regardless of gimbal state.
- LUT values are unsigned Q1.16: cos(0) = 65536, sin(0) = 0, and index 63 ≈ 90°.
- All arithmetic is unsigned N-bit. Intermediate products use 2N bits and truncate to N on assignment.

Decomposition:
- Package saturn_ascent_pkg: GRAVITY, STEPS_PER_SEC, ALT_GIMBAL, PITCH_RATE, LUT_BITS, N.
- One sub-module, quarter_sine_lut: index in, sin and cos Q1.16 out, combinational.
- Velocity, gimbal and altitude logic stay in the top module.

Test Plan:
- Stage 1 with Isp 363, initial_weight 2,877,403, propellant_weight 2,077,000, burntime 48, stage restart then release:
  - mdot = 43,270 and F = 153,912,990,990 mN.
  - After the first step, velocity = 43,691.
- Isp 300, initial_weight 1000, propellant_weight 100, burntime 1:
  - ignition_end rises exactly 1000 cycles after restart release.
  - after_weight = 900.
  - velocity is frozen afterwards.
- backward = 1 from rest:
  - velocity stays 0 (gravity saturation).
  - after_weight is unchanged.
- height driven from 29,999,999,999,000 to 30,000,000,000,000:
  - gimbal_enable rises on that edge.
  - noair_altitude = 30,000,000,000,000.
  - angular_velocity = 42,950.
- After pitch-over, with height stepping +1,000,000 per cycle while theta is still in LUT index 0:
  - additional_altitude += 1,000,000 per cycle.
  - distance stays 0.
- RESETB asserted mid-burn: all outputs are 0 asynchronously; the gimbal re-arms.
